// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU load/store path has priority. The host port wins after
// STARVE_LIMIT waiting cycles, then owns memory for a locked, auto-incrementing burst.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int LEN_WIDTH    = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_stall_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [LEN_WIDTH-1:0]  host_len_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic                  host_busy_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  mem_writemem_o,
  output logic                  mem_readmem_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i
);

  localparam int STARVE_WIDTH = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arbState;

  arbState                 stateReg, stateNext;
  logic [STARVE_WIDTH-1:0] starveCntReg, starveCntNext;
  logic [LEN_WIDTH-1:0]    beatCntReg, beatCntNext;
  logic [LEN_WIDTH-1:0]    lenReg, lenNext;
  logic [ADDR_WIDTH-1:0]   baseReg, baseNext;
  logic                    weReg, weNext;

  logic                    cpuRvalidReg, hostRvalidReg;
  logic [DATA_WIDTH-1:0]   cpuRdataReg, hostRdataReg;

  logic                    cpuGnt, hostGnt, grantWe, starveSat;
  logic [ADDR_WIDTH-1:0]   grantAddr;
  logic [DATA_WIDTH-1:0]   grantData;

  assign starveSat = (starveCntReg >= STARVE_MAX);

  // Grant and burst sequencing; nothing is granted while reset is asserted.
  always_comb begin
    stateNext   = stateReg;
    beatCntNext = beatCntReg;
    lenNext     = lenReg;
    baseNext    = baseReg;
    weNext      = weReg;
    cpuGnt      = 1'b0;
    hostGnt     = 1'b0;
    grantWe     = 1'b0;
    grantAddr   = '0;
    grantData   = '0;
    if (!rst_i) begin
      case (stateReg)
        IDLE: begin
          if (host_req_i && (!cpu_req_i || starveSat)) begin
            hostGnt   = 1'b1;
            grantWe   = host_we_i;
            grantAddr = host_addr_i;
            grantData = host_wdata_i;
            baseNext  = host_addr_i;
            weNext    = host_we_i;
            lenNext   = host_len_i;
            if (host_len_i != '0) begin
              stateNext   = BURST;
              beatCntNext = LEN_WIDTH'(1);
            end else begin
              beatCntNext = '0;
            end
          end else if (cpu_req_i) begin
            cpuGnt    = 1'b1;
            grantWe   = cpu_we_i;
            grantAddr = cpu_addr_i;
            grantData = cpu_wdata_i;
          end
        end
        BURST: begin
          hostGnt   = 1'b1;
          grantWe   = weReg;
          grantAddr = baseReg + ADDR_WIDTH'(beatCntReg);
          grantData = host_wdata_i;
          if (beatCntReg == lenReg) begin
            stateNext   = IDLE;
            beatCntNext = '0;
          end else begin
            beatCntNext = beatCntReg + LEN_WIDTH'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    starveCntNext = starveCntReg;
    if (hostGnt) begin
      starveCntNext = '0;
    end else if (host_req_i && !starveSat) begin
      starveCntNext = starveCntReg + STARVE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      stateReg     <= IDLE;
      starveCntReg <= '0;
      beatCntReg   <= '0;
      lenReg       <= '0;
      baseReg      <= '0;
      weReg        <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      starveCntReg <= starveCntNext;
      beatCntReg   <= beatCntNext;
      lenReg       <= lenNext;
      baseReg      <= baseNext;
      weReg        <= weNext;
    end
  end

  // Read return: datamem q is valid the cycle after the read edge, which is when
  // rvalid is high; the holding register keeps it once rvalid drops.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cpuRvalidReg  <= 1'b0;
      hostRvalidReg <= 1'b0;
      cpuRdataReg   <= '0;
      hostRdataReg  <= '0;
    end else begin
      cpuRvalidReg  <= cpuGnt & ~grantWe;
      hostRvalidReg <= hostGnt & ~grantWe;
      if (cpuRvalidReg) begin
        cpuRdataReg <= mem_q_i;
      end
      if (hostRvalidReg) begin
        hostRdataReg <= mem_q_i;
      end
    end
  end

  assign cpu_gnt_o      = cpuGnt;
  assign cpu_stall_o    = cpu_req_i & ~cpuGnt;
  assign cpu_rvalid_o   = cpuRvalidReg;
  assign cpu_rdata_o    = cpuRvalidReg ? mem_q_i : cpuRdataReg;
  assign host_gnt_o     = hostGnt;
  assign host_busy_o    = (stateReg == BURST);
  assign host_rvalid_o  = hostRvalidReg;
  assign host_rdata_o   = hostRvalidReg ? mem_q_i : hostRdataReg;
  assign mem_writemem_o = (cpuGnt | hostGnt) & grantWe;
  assign mem_readmem_o  = (cpuGnt | hostGnt) & ~grantWe;
  assign mem_addr_o     = grantAddr;
  assign mem_data_o     = grantData;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, all checked against
// a transaction-level model (burst counters and a shadow memory array).
module tb_dmem_arbiter;
  localparam int AW = 8, DW = 8, LW = 4, SL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i;
  logic          cpu_req_i, cpu_we_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wdata_i;
  logic          cpu_gnt_o, cpu_stall_o, cpu_rvalid_o;
  logic [DW-1:0] cpu_rdata_o;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [LW-1:0] host_len_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_gnt_o, host_busy_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_writemem_o, mem_readmem_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [DW-1:0] mem_q_i = '0;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_stall_o(cpu_stall_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_len_i(host_len_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_busy_o(host_busy_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_writemem_o(mem_writemem_o), .mem_readmem_o(mem_readmem_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_q_i(mem_q_i)
  );

  // Datamem stand-in driven by the DUT; shadow is what the model says memory should hold.
  logic [DW-1:0] ram    [0:255];
  logic [DW-1:0] shadow [0:255];
  always @(posedge clk) begin
    if (mem_readmem_o)  mem_q_i <= ram[mem_addr_o];
    if (mem_writemem_o) ram[mem_addr_o] <= mem_data_o;
  end

  // Model state
  int            mLeft, mStarve;
  logic [AW-1:0] mNext;
  logic          mWe, mCpuRv, mHostRv;
  logic [DW-1:0] mCpuData, mHostData, mCpuHeld, mHostHeld;
  logic          pCpuGnt, pHostGnt, pStart, pWe;
  logic [AW-1:0] pAddr;
  logic [DW-1:0] pData;

  // {cpu_gnt, stall, cpu_rv, cpu_rdata, host_gnt, busy, host_rv, host_rdata, we, re, addr, data}
  logic [39:0] expVec, obsVec;
  int checks = 0, passes = 0, cyc = 0;

  task automatic predict();
    pCpuGnt = 0; pHostGnt = 0; pStart = 0; pWe = 0; pAddr = '0; pData = '0;
    if (!rst_i) begin
      if (mLeft > 0) begin
        pHostGnt = 1; pWe = mWe; pAddr = mNext; pData = host_wdata_i;
      end else if (host_req_i && (!cpu_req_i || mStarve >= SL)) begin
        pHostGnt = 1; pStart = 1; pWe = host_we_i; pAddr = host_addr_i; pData = host_wdata_i;
      end else if (cpu_req_i) begin
        pCpuGnt = 1; pWe = cpu_we_i; pAddr = cpu_addr_i; pData = cpu_wdata_i;
      end
    end
    expVec = {pCpuGnt, cpu_req_i & ~pCpuGnt, mCpuRv, (mCpuRv ? mCpuData : mCpuHeld),
              pHostGnt, (mLeft > 0), mHostRv, (mHostRv ? mHostData : mHostHeld),
              (pCpuGnt | pHostGnt) & pWe, (pCpuGnt | pHostGnt) & ~pWe, pAddr, pData};
  endtask

  task automatic commit();
    if (rst_i) begin
      mLeft = 0; mStarve = 0; mCpuRv = 0; mHostRv = 0; mCpuHeld = '0; mHostHeld = '0;
    end else begin
      if (mCpuRv)  mCpuHeld  = mCpuData;
      if (mHostRv) mHostHeld = mHostData;
      mCpuRv  = pCpuGnt && !pWe;
      mHostRv = pHostGnt && !pWe;
      if (pCpuGnt || pHostGnt) begin
        if (pWe)          shadow[pAddr] = pData;
        else if (pCpuGnt) mCpuData  = shadow[pAddr];
        else              mHostData = shadow[pAddr];
      end
      if (pHostGnt) mStarve = 0;
      else if (host_req_i && mStarve < SL) mStarve++;
      if (pStart) begin
        mLeft = int'(host_len_i); mNext = host_addr_i + 8'd1; mWe = host_we_i;
      end else if (pHostGnt) begin
        mLeft--; mNext = mNext + 8'd1;
      end
    end
  endtask

  task automatic cycle();
    predict();
    @(negedge clk);
    obsVec = {cpu_gnt_o, cpu_stall_o, cpu_rvalid_o, cpu_rdata_o, host_gnt_o, host_busy_o,
              host_rvalid_o, host_rdata_o, mem_writemem_o, mem_readmem_o, mem_addr_o, mem_data_o};
    @(posedge clk);
    commit();
    cyc++;
    #1;
  endtask

  task automatic setIdle();
    rst_i = 0; cpu_req_i = 0; cpu_we_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
    host_req_i = 0; host_we_i = 0; host_addr_i = '0; host_len_i = '0; host_wdata_i = '0;
  endtask

  task automatic doReset();
    setIdle(); rst_i = 1; cycle(); rst_i = 0;
  endtask

  task automatic test_reset();
    setIdle(); rst_i = 1; cpu_req_i = 1; host_req_i = 1; host_we_i = 1;
    cycle();
    checks++;
    if (obsVec[39] !== 1'b0 || obsVec[28] !== 1'b0 || obsVec[17:16] !== 2'b00) begin
      $display("FAIL reset_no_grant cyc=%0d got=%h required gnt/mem=0", cyc, obsVec);
    end else passes++;
    setIdle();
    cycle();
    checks++;
    if (obsVec !== 40'h0) $display("FAIL reset_idle cyc=%0d got=%h required=0", cyc, obsVec);
    else passes++;
  endtask

  task automatic test_cpu_only();
    for (int k = 0; k < 3; k++) begin
      setIdle();
      if (k < 2) begin cpu_req_i = 1; cpu_we_i = (k == 0); cpu_addr_i = 8'h10; cpu_wdata_i = 8'h5A; end
      cycle();
      checks++;
      if (obsVec !== expVec) $display("FAIL cpu_only cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
      checks++;
      if (obsVec[39] !== (k < 2) || obsVec[38] !== 1'b0)
        $display("FAIL cpu_only_gnt cyc=%0d gnt=%b stall=%b", cyc, obsVec[39], obsVec[38]);
      else passes++;
    end
    checks++;
    if (obsVec[37] !== 1'b1 || obsVec[36:29] !== 8'h5A)
      $display("FAIL cpu_readback cyc=%0d rv=%b rdata=%h required 1/5a", cyc, obsVec[37], obsVec[36:29]);
    else passes++;
  endtask

  task automatic test_host_write_burst();
    logic [7:0] a;
    for (int k = 0; k < 4; k++) begin
      setIdle();
      host_req_i = (k == 0); host_we_i = 1; host_addr_i = (k == 0) ? 8'h20 : 8'hEE;
      host_len_i = 4'd3; host_wdata_i = 8'(k + 1);
      cycle();
      a = 8'h20 + 8'(k);
      checks++;
      if (obsVec !== expVec) $display("FAIL host_wr cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
      checks++;
      if (obsVec[15:8] !== a || obsVec[27] !== (k > 0) || obsVec[28] !== 1'b1 || obsVec[17] !== 1'b1)
        $display("FAIL host_wr_beat cyc=%0d addr=%h busy=%b required addr=%h busy=%b", cyc, obsVec[15:8], obsVec[27], a, (k > 0));
      else passes++;
    end
    setIdle(); cycle();
    checks++;
    if (obsVec[28:27] !== 2'b00) $display("FAIL host_wr_end cyc=%0d gnt/busy=%b required 00", cyc, obsVec[28:27]);
    else passes++;
    cpu_req_i = 1; cpu_addr_i = 8'h22; cycle();
    setIdle(); cycle();
    checks++;
    if (obsVec[37] !== 1'b1 || obsVec[36:29] !== 8'h03)
      $display("FAIL host_wr_readback cyc=%0d rv=%b rdata=%h required 1/03", cyc, obsVec[37], obsVec[36:29]);
    else passes++;
  endtask

  task automatic test_starvation();
    logic [2:0] want;
    doReset();
    for (int i = 0; i < 9; i++) begin
      setIdle();
      cpu_req_i = 1; cpu_addr_i = 8'($urandom); host_req_i = (i <= 4); host_we_i = 1;
      host_addr_i = 8'h80; host_len_i = 4'd2; host_wdata_i = 8'($urandom);
      cycle();
      checks++;
      if (obsVec !== expVec) $display("FAIL starve cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
      want = {(i < 4 || i > 6), (i >= 4 && i <= 6), (i >= 4 && i <= 6)};
      checks++;
      if ({obsVec[39], obsVec[38], obsVec[28]} !== want)
        $display("FAIL starve_order i=%0d cgnt/stall/hgnt=%b required %b", i, {obsVec[39], obsVec[38], obsVec[28]}, want);
      else passes++;
    end
  endtask

  task automatic test_wrap();
    logic [7:0] a;
    for (int k = 0; k < 6; k++) begin
      setIdle();
      host_req_i = (k == 0); host_we_i = 0; host_addr_i = 8'hFE; host_len_i = 4'd3;
      cycle();
      a = 8'hFE + 8'(k);
      checks++;
      if (obsVec !== expVec) $display("FAIL wrap cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
      checks++;
      if ((k < 4 && (obsVec[15:8] !== a || obsVec[16] !== 1'b1)) || obsVec[26] !== (k >= 1 && k <= 4))
        $display("FAIL wrap_addr k=%0d addr=%h rv=%b required addr=%h", k, obsVec[15:8], obsVec[26], a);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [7:0] saved [0:7];
    for (int i = 0; i < 8; i++) saved[i] = ram[8'h40 + i];
    for (int k = 0; k < 3; k++) begin
      setIdle();
      host_req_i = (k == 0); host_we_i = 1; host_addr_i = 8'h40; host_len_i = 4'd7;
      host_wdata_i = 8'hC0 + 8'(k); rst_i = (k == 2);
      cycle();
      checks++;
      if (obsVec !== expVec) $display("FAIL rst_burst cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
    end
    checks++;
    if (obsVec[17] !== 1'b0) $display("FAIL rst_burst_nowrite cyc=%0d we=%b required 0", cyc, obsVec[17]);
    else passes++;
    setIdle(); cycle();
    checks++;
    if (obsVec[27] !== 1'b0 || obsVec[28] !== 1'b0 || obsVec[17] !== 1'b0)
      $display("FAIL rst_burst_idle cyc=%0d busy=%b gnt=%b we=%b required 0", cyc, obsVec[27], obsVec[28], obsVec[17]);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] want;
      want = (i == 0) ? 8'hC0 : (i == 1) ? 8'hC1 : saved[i];
      checks++;
      if (ram[8'h40 + i] !== want) $display("FAIL rst_burst_mem a=%0h got=%h required=%h", 8'h40 + i, ram[8'h40 + i], want);
      else passes++;
    end
  endtask

  task automatic test_simultaneous();
    doReset();
    for (int i = 0; i < 4; i++) begin
      setIdle();
      cpu_req_i = (i < 3); cpu_addr_i = 8'h33; host_req_i = 1; host_we_i = 1;
      host_addr_i = 8'h34; host_len_i = 4'd0; host_wdata_i = 8'h77;
      cycle();
      checks++;
      if (obsVec !== expVec) $display("FAIL simul cyc=%0d got=%h required=%h", cyc, obsVec, expVec);
      else passes++;
      checks++;
      if (obsVec[39] !== (i < 3) || obsVec[28] !== (i == 3) || obsVec[27] !== 1'b0)
        $display("FAIL simul_order i=%0d cgnt=%b hgnt=%b busy=%b", i, obsVec[39], obsVec[28], obsVec[27]);
      else passes++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      rst_i        = ($urandom_range(0, 79) == 0);
      cpu_req_i    = ($urandom_range(0, 9) < 6);
      cpu_we_i     = $urandom_range(0, 1) == 1;
      cpu_addr_i   = 8'($urandom);
      cpu_wdata_i  = 8'($urandom);
      host_req_i   = ($urandom_range(0, 9) < 3);
      host_we_i    = $urandom_range(0, 1) == 1;
      host_addr_i  = 8'($urandom);
      host_len_i   = 4'($urandom_range(0, 5));
      host_wdata_i = 8'($urandom);
      cycle();
      checks++;
      if (obsVec !== expVec) $display("FAIL random n=%0d cyc=%0d got=%h required=%h", n, cyc, obsVec, expVec);
      else passes++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      ram[i] = v; shadow[i] = v;
    end
    mLeft = 0; mStarve = 0; mNext = '0; mWe = 0; mCpuRv = 0; mHostRv = 0;
    mCpuData = '0; mHostData = '0; mCpuHeld = '0; mHostHeld = '0;
    setIdle(); rst_i = 1;
    @(posedge clk); #1;
    test_reset();
    test_cpu_only();
    test_host_write_burst();
    test_starvation();
    test_wrap();
    test_reset_mid_burst();
    test_simultaneous();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store path and a host loader/debug port.
- Sits between control/alu (CPU side), the host interface, and datamem.
- CPU has priority. The host wins arbitration after a bounded wait, then owns memory for a locked burst with auto-incrementing addresses.
- Stalls the CPU (fetch holds PC) while the host owns memory.

Parameters:
- ADDR_WIDTH, 8, data memory address width (matches datamem).
- DATA_WIDTH, 8, data word width.
- LEN_WIDTH, 4, host burst length field width; burst = host_len_i+1 beats.
- STARVE_LIMIT, 4, host-waiting cycles after which the host beats a pending CPU request.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_req_i  in  1  CPU memory access request (read_mem | write_mem).
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  ADDR_WIDTH  CPU address (alu result).
- cpu_wdata_i  in  DATA_WIDTH  CPU write data (reg2 data).
- cpu_gnt_o  out  1  CPU access performed this cycle.
- cpu_stall_o  out  1  cpu_req_i & ~cpu_gnt_o; drives fetch hold.
- cpu_rvalid_o  out  1  CPU read data valid (one cycle after grant).
- cpu_rdata_o  out  DATA_WIDTH  CPU read data.
- host_req_i  in  1  host burst request.
- host_we_i  in  1  burst direction.
- host_addr_i  in  ADDR_WIDTH  burst base address.
- host_len_i  in  LEN_WIDTH  beats minus one.
- host_wdata_i  in  DATA_WIDTH  write data, consumed on each host_gnt_o beat.
- host_gnt_o  out  1  one host beat performed this cycle.
- host_busy_o  out  1  burst in progress.
- host_rvalid_o  out  1  host read data valid.
- host_rdata_o  out  DATA_WIDTH  host read data.
- mem_writemem_o  out  1  to datamem writemem.
- mem_readmem_o  out  1  to datamem readmem.
- mem_addr_o  out  ADDR_WIDTH  to datamem addr.
- mem_data_o  out  DATA_WIDTH  to datamem data.
- mem_q_i  in  DATA_WIDTH  datamem q (registered, valid one cycle after the read edge).

Behaviour:
- State machine: IDLE, BURST.
- Registers: starve_cnt (saturating), beat counter, latched base address, latched we, latched len, rvalid/rdata.
- Reset values:
  - State IDLE; all counters 0.
  - cpu_rvalid_o = host_rvalid_o = 0.
  - cpu_rdata_o = host_rdata_o = 0.
  - In IDLE with no requests, mem_* are all 0 and all grants are 0.
- Grant in IDLE (combinational, same cycle as request):
  - Host wins if host_req_i & (~cpu_req_i | starve_cnt >= STARVE_LIMIT). It performs beat 0 this cycle (host_gnt_o=1), latches addr/we/len, and goes to BURST, unless len==0, in which case it stays IDLE.
  - Otherwise, if cpu_req_i, the CPU wins (cpu_gnt_o=1).
- BURST:
  - The host owns memory. Beat k uses address (base+k) mod 2^ADDR_WIDTH, so the address wraps at the top.
  - host_gnt_o=1 every cycle of the burst. host_busy_o=1 from the cycle after beat 0 through the final beat.
  - After beat len the state returns to IDLE, and the CPU can be granted in the following cycle.
  - host_req_i and host_addr_i are ignored during a burst. Deasserting host_req_i does not abort the burst.
- starve_cnt:
  - +1 each cycle host_req_i=1 and host is not granted, saturating at STARVE_LIMIT.
  - Cleared on any host grant.
- Memory drive:
  - mem_writemem_o = granted & we.
  - mem_readmem_o = granted & ~we.
  - mem_addr_o and mem_data_o come from the granted source.
  - Never both mem_writemem_o and mem_readmem_o asserted.
  - At most one of cpu_gnt_o and host_gnt_o per cycle.
- Read return:
  - A read granted in cycle n gives *_rvalid_o=1 in n+1, with *_rdata_o = mem_q_i captured into the register in n+1.
  - Back-to-back reads give one rvalid per cycle.
  - rdata holds its last value when rvalid=0.
- Reset mid-burst: aborts the burst, returns to IDLE, and drops pending rvalid. No memory access occurs in the reset cycle.

Test Plan:
- CPU only: write 0x5A to addr 0x10, then read 0x10 -> cpu_gnt_o=1 both cycles; cpu_rvalid_o=1 the cycle after the read with cpu_rdata_o=0x5A; cpu_stall_o never 1.
- Host write burst: base 0x20, len 3, data 1,2,3,4, CPU idle -> mem_addr_o 0x20..0x23 on consecutive cycles; host_busy_o high cycles 1-3; IDLE after 4 beats; a CPU read of 0x22 returns 3.
- Starvation (STARVE_LIMIT=4): CPU requests every cycle, host requests from cycle 0 -> CPU granted cycles 0-3, host granted cycle 4; cpu_stall_o=1 for the whole burst; starve_cnt cleared.
- Wrap: host read burst, base 0xFE, len 3 -> addresses 0xFE, 0xFF, 0x00, 0x01; host_rvalid_o for 4 consecutive cycles lagging by 1.
- Reset mid-burst: rst_i=1 at beat 2 of a len-7 write burst -> next cycle IDLE, mem_writemem_o=0, host_busy_o=0; memory above beat 1 unchanged.
- Simultaneous request with starve_cnt=0: cpu_req_i and host_req_i both 1 -> CPU granted; host granted the first cycle cpu_req_i=0.
